regfile_wb_arbiter: RTL and testbench

Write-side front end for the core's integer register file. Merges writeback requests from the execute unit (EXU) and the load/store unit (LSU) through valid/ready handshakes, arbitrates them onto the register file's single write port, and drives its `wen`/`rd`/`dataD` inputs from registers. Writes to x0 are accepted and discarded. A starvation counter guarantees EXU progress under sustained LSU traffic.

---
 rtl/lemon_pkg.sv | 20 ++
 rtl/wb_prio_arb.sv | 58 +++++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/lemon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lemon_pkg
// Description : Shared core constants and the writeback source enumeration
//               used by the register-file writeback arbiter and its trace.
// Revision    : 1.0 - initial release
// ============================================================================
package lemon_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // Which unit produced a writeback; used by the trace and by bypass logic.
    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage : lemon_pkg
`default_nettype wire

// File: rtl/wb_prio_arb.sv
`default_nettype none
// ============================================================================
// Module      : wb_prio_arb
// Description : Two-requester priority arbiter (LSU over EXU) with a
//               starvation counter that forces an EXU grant after
//               STARVE_LIMIT consecutive LSU grants while EXU waits.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               exu_valid, lsu_valid     - requests
//               exu_ready, lsu_ready     - combinational readies
//               exu_grant, lsu_grant     - valid & ready per requester
//               force_exu                - starvation override active
// Revision    : 1.0 - initial release
// ============================================================================
module wb_prio_arb
    import lemon_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic exu_valid,
    input  logic lsu_valid,
    output logic exu_ready,
    output logic lsu_ready,
    output logic exu_grant,
    output logic lsu_grant,
    output logic force_exu
);

    localparam int                CNT_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_starve_cnt;

    // Readies depend only on the requesters; the register file never stalls.
    always_comb begin
        force_exu = exu_valid && (r_starve_cnt == C_CNT_LIMIT);
        lsu_ready = !rst && !force_exu;
        exu_ready = !rst && (!lsu_valid || force_exu);
        lsu_grant = lsu_valid && lsu_ready;
        exu_grant = exu_valid && exu_ready;
    end

    // Counts LSU wins while EXU is left waiting; any EXU win or an idle EXU
    // restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (exu_grant || !exu_valid) begin
            r_starve_cnt <= '0;
        end else if (lsu_grant && (r_starve_cnt != C_CNT_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + C_CNT_ONE;
        end
    end

endmodule : wb_prio_arb
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Write-side front end for the integer register file. Merges
//               EXU and LSU writeback handshakes onto the single write port,
//               registers wen/rd/dataD, and discards writes to x0.
// Ports       : clk, rst                         - clock, sync active-high reset
//               exu_valid/ready/rd/data          - EXU writeback channel
//               lsu_valid/ready/rd/data          - LSU writeback channel
//               rf_wen, rf_rd, rf_dataD          - registered write port
// Config      : RF_WB_TRACE_EN - simulation trace of every committed write
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import lemon_pkg::*;
#(
    parameter int ADDR_WIDTH   = REG_ADDR_W,
    parameter int DATA_WIDTH   = XLEN,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_dataD
);

    logic                  w_exu_grant;
    logic                  w_lsu_grant;
    logic                  w_force_exu;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;

    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_data;

    wb_prio_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .lsu_valid (lsu_valid),
        .exu_ready (exu_ready),
        .lsu_ready (lsu_ready),
        .exu_grant (w_exu_grant),
        .lsu_grant (w_lsu_grant),
        .force_exu (w_force_exu)
    );

    // Grants are mutually exclusive, so a simple select is sufficient.
    always_comb begin
        w_accept   = w_exu_grant || w_lsu_grant;
        w_sel_rd   = w_lsu_grant ? lsu_rd   : exu_rd;
        w_sel_data = w_lsu_grant ? lsu_data : exu_data;
    end

    // x0 writes complete their handshake and update rd/data, but never pulse
    // wen. Idle cycles hold rd/data and drop wen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen  <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_wen  <= (w_sel_rd != '0);
            r_rd   <= w_sel_rd;
            r_data <= w_sel_data;
        end else begin
            r_wen  <= 1'b0;
        end
    end

    assign rf_wen   = r_wen;
    assign rf_rd    = r_rd;
    assign rf_dataD = r_data;

`ifdef RF_WB_TRACE_EN
    wb_src_e               r_src;
    logic [DATA_WIDTH-1:0] r_shadow [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src <= WB_EXU;
        end else if (w_accept) begin
            r_src <= w_lsu_grant ? WB_LSU : WB_EXU;
        end
    end

    // Shadow copy mirrors the register file so the old value can be shown.
    always_ff @(posedge clk) begin
        if (r_wen) begin
            $display("wb %s x%0d <- 0x%h(%0d) old=0x%h",
                     (r_src == WB_LSU) ? "lsu" : "exu", r_rd, r_data,
                     $signed(r_data), r_shadow[r_rd]);
            r_shadow[r_rd] <= r_data;
        end
    end
`else
    logic w_unused_force;
    assign w_unused_force = w_force_exu;
`endif

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter with a
//               reference arbitration model and an expected-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 64;
    localparam int LIM = 3;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          exu_valid, lsu_valid;
    logic          exu_ready, lsu_ready;
    logic [AW-1:0] exu_rd, lsu_rd;
    logic [DW-1:0] exu_data, lsu_data;
    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_dataD;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            m_cnt  = 0;
    logic [AW-1:0] m_rd   = '0;
    logic [DW-1:0] m_data = '0;
    wr_t           sb_q[$];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_wen    (rf_wen),
        .rf_rd     (rf_rd),
        .rf_dataD  (rf_dataD)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check readies, predict the write,
    // then check the registered outputs just after the posedge.
    task automatic step(input logic r,
                        input logic ev, input logic [AW-1:0] erd, input logic [DW-1:0] ed,
                        input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
        logic f, exp_lr, exp_er, lg, eg;
        wr_t  item, got;
        @(negedge clk);
        rst = r;
        exu_valid = ev; exu_rd = erd; exu_data = ed;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
        f      = ev && (m_cnt == LIM);
        exp_lr = !r && !f;
        exp_er = !r && (!lv || f);
        chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, exp_lr});
        chk("exu_ready", {63'd0, exu_ready}, {63'd0, exp_er});
        lg = lv && exp_lr;
        eg = ev && exp_er;
        if (r)       item = '{wen: 1'b0, rd: '0, data: '0};
        else if (lg) item = '{wen: (lrd != 0), rd: lrd, data: ld};
        else if (eg) item = '{wen: (erd != 0), rd: erd, data: ed};
        else         item = '{wen: 1'b0, rd: m_rd, data: m_data};
        m_rd   = item.rd;
        m_data = item.data;
        sb_q.push_back(item);
        if (r || eg || !ev)              m_cnt = 0;
        else if (lg && m_cnt < LIM)      m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            chk("rf_wen",   {63'd0, rf_wen}, {63'd0, got.wen});
            chk("rf_rd",    {59'd0, rf_rd},  {59'd0, got.rd});
            chk("rf_dataD", rf_dataD,        got.data);
        end
    endtask

    initial begin
        rst = 1'b1;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

        // Reset with both requesters asking
        step(1, 1, 5'd3, 64'h11, 1, 5'd4, 64'h22);
        step(1, 1, 5'd3, 64'h11, 1, 5'd4, 64'h22);
        // Idle after release
        step(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        step(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);

        // Single EXU write, then idle shows wen dropping
        step(0, 1, 5'd5, 64'h1234, 0, 5'd0, 64'h0);
        step(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);

        // Sustained contention: LSU,LSU,LSU,EXU repeating.
        // EXU holds its request stable until granted.
        begin
            logic [DW-1:0] ed;
            ed = 64'hE000;
            for (int i = 0; i < 12; i++) begin
                step(0, 1, 5'd11, ed, 1, 5'd10, 64'hA000 + 64'(i));
                if ((i % 4) == 3) ed = ed + 64'd1;
            end
        end
        step(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);

        // x0 discard from LSU and from EXU
        step(0, 0, 5'd0, 64'h0, 1, 5'd0, 64'hdead);
        step(0, 1, 5'd0, 64'hbeef, 0, 5'd0, 64'h0);
        step(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);

        // Reset mid-stream clears the pending pulse and the starvation count
        step(0, 1, 5'd12, 64'hC1, 1, 5'd13, 64'hD1);
        step(0, 1, 5'd12, 64'hC1, 1, 5'd13, 64'hD2);
        step(1, 1, 5'd12, 64'hC1, 1, 5'd13, 64'hD3);
        for (int i = 0; i < 5; i++)
            step(0, 1, 5'd12, 64'hC1, 1, 5'd13, 64'hD4 + 64'(i));
        step(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);

        // Back-to-back LSU stream, EXU idle
        for (int i = 1; i <= 8; i++)
            step(0, 0, 5'd0, 64'h0, 1, 5'(i), 64'hF0F0_0000_0000_0000 | 64'(i * 17));
        step(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
